// File: rtl/level_ram_if.sv
// Controller-side bus of the level RAM: access request signals and the status/read-back returned by the RAM.
interface level_ram_if;
  logic [7:0] address_in;
  logic [7:0] data_in;
  logic       r_w;
  logic       clear_req;
  logic [7:0] data_out;
  logic       busy;
  logic       oob;
  logic [7:0] wr_count;
  logic [7:0] max_level;

  modport master (
    output address_in, data_in, r_w, clear_req,
    input  data_out, busy, oob, wr_count, max_level
  );

  modport slave (
    input  address_in, data_in, r_w, clear_req,
    output data_out, busy, oob, wr_count, max_level
  );
endinterface

// File: rtl/level_ram.sv
// Level RAM: self-clearing 8-bit store with registered reads, out-of-range flagging and a saturating write counter.
// Max-level tracking is built only when LEVEL_RAM_MAX_TRACK_EN is defined; otherwise max_level is tied to zero.
module level_ram #(
  parameter int DEPTH = 8
) (
  input logic      clk,
  input logic      reset,
  level_ram_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {CLEAR, SERVE} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] index;
  logic [7:0]       mem [DEPTH];
  logic [IDX_W-1:0] addr_idx;
  logic             in_range;
  logic             last_clear;
  logic             serve_access;
  logic             wr_accept;
  logic             busy_o;
  logic [7:0]       data_out_q;
  logic             oob_q;
  logic [7:0]       wr_count_q;

  // Addresses are 8 bits wide but DEPTH may be 256, so compare in 9 bits.
  assign in_range     = ({1'b0, bus.address_in} < 9'(DEPTH));
  assign addr_idx     = bus.address_in[IDX_W-1:0];
  assign last_clear   = (index == IDX_W'(DEPTH - 1));
  assign serve_access = (state == SERVE) && !bus.clear_req && !reset;
  assign wr_accept    = serve_access && bus.r_w && in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (!bus.clear_req && last_clear) state_next = SERVE;
      SERVE:   if (bus.clear_req) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    if (state == CLEAR) busy_o = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear_req) begin
      index <= '0;
    end else if (state == CLEAR) begin
      index <= index + IDX_W'(1);
    end
  end

  // Storage has no reset; the clear walk zeroes it before any access is served.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[index] <= 8'h00;
    end else if (wr_accept) begin
      mem[addr_idx] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= 8'h00;
      oob_q      <= 1'b0;
      wr_count_q <= 8'h00;
    end else begin
      oob_q <= serve_access && !in_range;
      if (bus.clear_req) begin
        wr_count_q <= 8'h00;
      end else if (wr_accept && (wr_count_q != 8'hFF)) begin
        wr_count_q <= wr_count_q + 8'd1;
      end
      if (serve_access && !bus.r_w) begin
        data_out_q <= in_range ? mem[addr_idx] : 8'h00;
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.oob      = oob_q;
  assign bus.wr_count = wr_count_q;
  assign bus.busy     = busy_o;

`ifdef LEVEL_RAM_MAX_TRACK_EN
  logic [7:0] max_q;

  always_ff @(posedge clk) begin
    if (reset || bus.clear_req) begin
      max_q <= 8'h00;
    end else if (wr_accept && (bus.data_in > max_q)) begin
      max_q <= bus.data_in;
    end
  end

  assign bus.max_level = max_q;
`else
  assign bus.max_level = 8'h00;
`endif
endmodule

// File: tb/tb_level_ram.sv
// Self-checking bench for level_ram: directed vector table, corner-case sequences and random traffic
// compared against a behavioural model of the RAM.
module tb_level_ram;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  level_ram_if bus();

  level_ram #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: memory array, counters, and number of clear cycles still to run.
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_dout;
  logic [7:0] m_wr;
  logic [7:0] m_max;
  logic       m_oob;
  int         m_clear_left;

  typedef struct {
    logic       r_w;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_dout;
    logic       exp_oob;
    logic [7:0] exp_wr;
  } vec_t;

  vec_t vecs [12];

  task automatic modelStartClear();
    m_clear_left = DEPTH;
    m_oob        = 1'b0;
    m_wr         = 8'h00;
    m_max        = 8'h00;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
  endtask

  task automatic modelEdge();
    if (reset) begin
      modelStartClear();
      m_dout = 8'h00;
    end else if (bus.clear_req) begin
      modelStartClear();
    end else if (m_clear_left > 0) begin
      m_clear_left = m_clear_left - 1;
      m_oob        = 1'b0;
    end else begin
      m_oob = (int'(bus.address_in) >= DEPTH);
      if (bus.r_w) begin
        if (!m_oob) begin
          m_mem[int'(bus.address_in)] = bus.data_in;
          if (m_wr < 8'hFF) m_wr = m_wr + 8'd1;
`ifdef LEVEL_RAM_MAX_TRACK_EN
          if (bus.data_in > m_max) m_max = bus.data_in;
`endif
        end
      end else begin
        m_dout = m_oob ? 8'h00 : m_mem[int'(bus.address_in)];
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic clr, input logic rw,
                               input logic [7:0] addr, input logic [7:0] data);
    reset          = rst;
    bus.clear_req  = clr;
    bus.r_w        = rw;
    bus.address_in = addr;
    bus.data_in    = data;
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, ".data_out"},  bus.data_out,       m_dout);
    cmp({tag, ".busy"},      {7'b0, bus.busy},   {7'b0, (m_clear_left > 0)});
    cmp({tag, ".oob"},       {7'b0, bus.oob},    {7'b0, m_oob});
    cmp({tag, ".wr_count"},  bus.wr_count,       m_wr);
    cmp({tag, ".max_level"}, bus.max_level,      m_max);
  endtask

  // Counts consecutive busy samples starting with the current one, bounded so a stuck busy still ends.
  task automatic measureBusy(input string tag);
    int cnt;
    cnt = bus.busy ? 1 : 0;
    for (int i = 0; i < 30 && bus.busy; i++) begin
      tick();
      checkOutput(tag);
      if (bus.busy) cnt++;
    end
    cmp({tag, ".busy_cycles"}, 8'(cnt), 8'd8);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b0, 8'd0,   8'h00, 8'h00, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 8'd7,   8'h00, 8'h00, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 8'd2,   8'h05, 8'h00, 1'b0, 8'd1};
    vecs[3]  = '{1'b0, 8'd2,   8'h00, 8'h05, 1'b0, 8'd1};
    vecs[4]  = '{1'b1, 8'd9,   8'h07, 8'h05, 1'b1, 8'd1};
    vecs[5]  = '{1'b0, 8'd9,   8'h00, 8'h00, 1'b1, 8'd1};
    vecs[6]  = '{1'b0, 8'd2,   8'h00, 8'h05, 1'b0, 8'd1};
    vecs[7]  = '{1'b1, 8'd7,   8'hA0, 8'h05, 1'b0, 8'd2};
    vecs[8]  = '{1'b1, 8'hFF,  8'h3C, 8'h05, 1'b1, 8'd2};
    vecs[9]  = '{1'b0, 8'd7,   8'h00, 8'hA0, 1'b0, 8'd2};
    vecs[10] = '{1'b1, 8'd7,   8'h11, 8'hA0, 1'b0, 8'd3};
    vecs[11] = '{1'b0, 8'd7,   8'h00, 8'h11, 1'b0, 8'd3};

    $display("[TB] reset and initial clear");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'h00);
    tick();
    cmp("reset.data_out",  bus.data_out,      8'h00);
    cmp("reset.busy",      {7'b0, bus.busy},  8'd1);
    cmp("reset.oob",       {7'b0, bus.oob},   8'd0);
    cmp("reset.wr_count",  bus.wr_count,      8'h00);
    cmp("reset.max_level", bus.max_level,     8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    measureBusy("init_clear");

    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'(a), 8'h00);
      tick();
      cmp("zero_read", bus.data_out, 8'h00);
    end

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, vecs[i].r_w, vecs[i].addr, vecs[i].data);
      tick();
      cmp($sformatf("vec%0d.data_out", i), bus.data_out,     vecs[i].exp_dout);
      cmp($sformatf("vec%0d.oob", i),      {7'b0, bus.oob},  {7'b0, vecs[i].exp_oob});
      cmp($sformatf("vec%0d.wr_count", i), bus.wr_count,     vecs[i].exp_wr);
      cmp($sformatf("vec%0d.busy", i),     {7'b0, bus.busy}, 8'd0);
    end

    $display("[TB] accesses during clear and clear restart");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd3, 8'h55);
    tick();
    cmp("clr.busy",     {7'b0, bus.busy}, 8'd1);
    cmp("clr.wr_count", bus.wr_count,     8'h00);
    cmp("clr.data_out", bus.data_out,     8'h11);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd3, 8'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("clr_write");
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd3, 8'h77);
    tick();
    checkOutput("clr_restart");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd3, 8'h77);
    measureBusy("clr_restart");
    cmp("clr.data_out_kept", bus.data_out, 8'h11);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd3, 8'h00);
    tick();
    cmp("clr.read_addr3", bus.data_out, 8'h00);
    cmp("clr.wr_after",   bus.wr_count, 8'h00);

    $display("[TB] write counter saturation");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, DEPTH - 1)), 8'($urandom));
      tick();
      checkOutput("sat");
    end
    cmp("sat.wr_count", bus.wr_count, 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'h00);
    tick();
    cmp("sat.wr_cleared", bus.wr_count, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
    measureBusy("sat_clear");

    $display("[TB] max level tracking");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd1, 8'h03);
    tick();
    checkOutput("max");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd2, 8'h09);
    tick();
    checkOutput("max");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd3, 8'h04);
    tick();
    checkOutput("max");
`ifdef LEVEL_RAM_MAX_TRACK_EN
    cmp("max.level", bus.max_level, 8'h09);
`else
    cmp("max.level", bus.max_level, 8'h00);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 39) == 0),
                    1'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, DEPTH - 1)),
                    8'($urandom));
      tick();
      checkOutput("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/level_ram.md
LEVEL_RAM -- requirements
Module: level_ram

Interface
REQ-001 Parameter: DEPTH, default 8, number of 8-bit entries; power of two, 2..256.
REQ-002 Port: clk, input, 1, sole clock; all logic on rising edge.
REQ-003 Port: reset, input, 1, synchronous, active-high reset.
REQ-004 Port: address_in, input, 8, entry address from the level controller.
REQ-005 Port: data_in, input, 8, write data from the level controller.
REQ-006 Port: r_w, input, 1, 1 = write, 0 = read; sampled every cycle when not busy.
REQ-007 Port: clear_req, input, 1, single-cycle request to restart the clear sequence.
REQ-008 Port: data_out, output, 8, registered read data to the controller.
REQ-009 Port: busy, output, 1, high while the clear sequence runs.
REQ-010 Port: oob, output, 1, one-cycle pulse on access with address_in >= DEPTH.
REQ-011 Port: wr_count, output, 8, count of accepted writes, saturating.
REQ-012 Port: max_level, output, 8, largest value ever written (see Configuration).

Function
REQ-013 The FSM SHALL have two states: CLEAR and SERVE.
REQ-014 CLEAR: one entry per cycle, index 0..DEPTH-1, written to 0x00; busy=1; leaves to SERVE the cycle after index DEPTH-1 is written (exactly DEPTH cycles in CLEAR).
REQ-015 SERVE: busy=0; one access per cycle selected by r_w.
REQ-016 Write (r_w=1, address_in < DEPTH) SHALL update mem[address_in] at that edge; data_out holds its previous value.
REQ-017 Read (r_w=0, address_in < DEPTH) SHALL present mem[address_in] on data_out one cycle later (latency 1); data_out holds until the next read.
REQ-018 A read issued the cycle after a write to the same address SHALL return the newly written value.
REQ-019 Out-of-range access: a write SHALL be dropped; a read SHALL load data_out=0x00; oob SHALL pulse high the following cycle in both cases.
REQ-020 Accepted in-range write SHALL increment wr_count by 1, saturating at 0xFF.
REQ-021 Accesses during CLEAR SHALL be ignored: no memory change, data_out unchanged, no oob, no wr_count change.
REQ-022 clear_req in SERVE SHALL enter CLEAR next cycle, restart at index 0, and clear wr_count; the same-cycle access is ignored.
REQ-023 clear_req in CLEAR SHALL restart the index at 0 (sequence lengthens).
REQ-024 clear_req in CLEAR SHALL NOT zero data_out; data_out is zeroed only by reset.

Reset
REQ-025 With reset=1 at an edge: state=CLEAR, index=0, data_out=0x00, busy=1, oob=0, wr_count=0x00, max_level=0x00.
REQ-026 Reset SHALL take priority over clear_req and any access; reset mid-CLEAR or mid-access restarts the clear from index 0.
REQ-027 Memory contents are not reset directly; the CLEAR sequence zeroes them before the first accepted access.

Configuration
REQ-028 Macro LEVEL_RAM_MAX_TRACK_EN controls max-level tracking.
REQ-029 Defined: on each accepted write with data_in > max_level, max_level SHALL load data_in next cycle. max_level is cleared by reset and clear_req only.
REQ-030 Undefined: max_level SHALL be tied to 0x00 and no tracking register is synthesized.

Verification
REQ-031 Reset 1 cycle, then idle -> busy=1 for exactly 8 cycles, then 0. Reads of addresses 0..7 return 0x00.
REQ-032 After clear: write 0x05 to addr 2, read addr 2 next cycle -> data_out=0x05 one cycle after the read. wr_count=1.
REQ-033 Write 0x07 to addr 9 -> oob pulses once, wr_count unchanged. Read addr 9 -> data_out=0x00 with oob pulse.
REQ-034 Write addr 3 during busy=1 -> ignored; after clear, read addr 3 -> 0x00.
REQ-035 300 writes, then clear_req -> wr_count saturates at 0xFF, then 0x00 after clear_req; busy high 8 cycles.
REQ-036 With LEVEL_RAM_MAX_TRACK_EN: write 0x03, 0x09, 0x04 -> max_level=0x09. Without the macro -> max_level=0x00 throughout.
